// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : draw_pkg
// Description : Shared constants and types for the VGA draw-port arbiter:
//               requester indices, FSM state encoding and default watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
package draw_pkg;

    // Number of pixel producers sharing the adapter port
    localparam int NUM_REQ     = 4;

    // Requester indices (bit position in req/grant)
    localparam int REQ_PIC     = 0;
    localparam int REQ_BRICK   = 1;
    localparam int REQ_PADDLE  = 2;
    localparam int REQ_BALL    = 3;

    // Per-requester slice widths on the packed pixel buses
    localparam int COORD_W     = 10;
    localparam int COLOUR_W    = 3;

    // Default grant hold limit; larger than a 160x120 full-screen blit
    localparam int DEF_TIMEOUT = 20000;

    // Arbiter state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_OWN  = OWN,
        ST_GAP  = GAP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/draw_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : draw_arbiter_if
// Description : Bundle of drawer-side request/pixel signals and adapter-side
//               pixel/status signals around the draw arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface draw_arbiter_if;

    logic [3:0]  req;
    logic [3:0]  done;
    logic [39:0] x_in;
    logic [39:0] y_in;
    logic [11:0] colour_in;
    logic [3:0]  plot_in;

    logic [3:0]  grant;
    logic [9:0]  vga_x;
    logic [9:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        timeout_err;
    logic [1:0]  timeout_id;

    // Drawers and adapter side
    modport master (
        output req, done, x_in, y_in, colour_in, plot_in,
        input  grant, vga_x, vga_y, vga_colour, vga_plot, busy,
               timeout_err, timeout_id
    );

    // Arbiter side
    modport slave (
        input  req, done, x_in, y_in, colour_in, plot_in,
        output grant, vga_x, vga_y, vga_colour, vga_plot, busy,
               timeout_err, timeout_id
    );

endinterface
`default_nettype wire

// File: rtl/draw_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner selection: optional fixed priority for
//               requester 0, otherwise round-robin search from ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick (
    input  wire logic [3:0] req,
    input  wire logic [1:0] ptr,
    input  wire logic       hipri,
    output logic      [1:0] win,
    output logic            any
);

    logic [1:0] w_idx;

    // Scan from ptr+4 (== ptr) down to ptr+1 so the nearest set bit wins
    always_comb begin
        win   = 2'd0;
        w_idx = 2'd0;
        any   = |req;
        if (hipri && req[0]) begin
            win = 2'd0;
        end else begin
            for (int i = 4; i >= 1; i--) begin
                w_idx = ptr + 2'(i);
                if (req[w_idx]) begin
                    win = w_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : draw_arbiter
// Description : Shares the VGA adapter write port among four drawers. One
//               owner at a time, held until done/withdraw/watchdog, with a
//               one-cycle gap between owners and registered pixel outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_arbiter #(
    parameter int NUM_REQ  = draw_pkg::NUM_REQ,
    parameter int HIPRI_EN = 1,
    parameter int TIMEOUT  = draw_pkg::DEF_TIMEOUT,
    parameter int CW       = 15
) (
    input  wire logic     clk,
    input  wire logic     resetn,
    draw_arbiter_if.slave bus
);

    import draw_pkg::*;

    state_t               r_state;
    logic [1:0]           r_ptr;
    logic [1:0]           r_owner;
    logic [CW-1:0]        r_wd;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_busy;
    logic [COORD_W-1:0]   r_vga_x;
    logic [COORD_W-1:0]   r_vga_y;
    logic [COLOUR_W-1:0]  r_vga_colour;
    logic                 r_vga_plot;
    logic                 r_timeout_err;
    logic [1:0]           r_timeout_id;

    logic [1:0]           w_win;
    logic                 w_any;
    logic                 w_timeout;
    logic                 w_release;
    logic                 w_hipri;

    assign w_hipri = (HIPRI_EN != 0);

    rr_pick u_rr_pick (
        .req   (bus.req),
        .ptr   (r_ptr),
        .hipri (w_hipri),
        .win   (w_win),
        .any   (w_any)
    );

    // Owner gives up the port on done, on withdrawing its request, or when
    // the watchdog hits its limit
    assign w_timeout = (r_wd == CW'(TIMEOUT - 1));
    assign w_release = bus.done[r_owner] | ~bus.req[r_owner] | w_timeout;

    // Arbitration FSM, pixel register and watchdog
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 2'd3;
            r_owner       <= 2'd0;
            r_wd          <= '0;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_vga_x       <= '0;
            r_vga_y       <= '0;
            r_vga_colour  <= '0;
            r_vga_plot    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_timeout_id  <= 2'd0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_vga_plot <= 1'b0;
                    if (w_any) begin
                        r_grant <= NUM_REQ'(1) << w_win;
                        r_busy  <= 1'b1;
                        r_owner <= w_win;
                        r_ptr   <= w_win;
                        r_wd    <= '0;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    // The release edge still registers the owner's pixel
                    r_vga_x      <= bus.x_in[int'(r_owner) * COORD_W +: COORD_W];
                    r_vga_y      <= bus.y_in[int'(r_owner) * COORD_W +: COORD_W];
                    r_vga_colour <= bus.colour_in[int'(r_owner) * COLOUR_W +: COLOUR_W];
                    r_vga_plot   <= bus.plot_in[r_owner];
                    if (w_release) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_GAP;
                        if (w_timeout) begin
                            r_timeout_err <= 1'b1;
                            r_timeout_id  <= r_owner;
                        end
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_GAP: begin
                    r_vga_plot <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_grant    <= '0;
                    r_busy     <= 1'b0;
                    r_vga_plot <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant[3:0];
    assign bus.busy        = r_busy;
    assign bus.vga_x       = r_vga_x;
    assign bus.vga_y       = r_vga_y;
    assign bus.vga_colour  = r_vga_colour;
    assign bus.vga_plot    = r_vga_plot;
    assign bus.timeout_err = r_timeout_err;
    assign bus.timeout_id  = r_timeout_id;

endmodule
`default_nettype wire

// File: tb/tb_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_arbiter
// Description : Self-checking bench for draw_arbiter: arbitration table,
//               pixel scoreboard, watchdog, withdraw and async reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_arbiter;

    localparam int TO = 20000;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp;
    } vec_t;

    logic clk;
    logic resetn;

    draw_arbiter_if ifh ();
    draw_arbiter_if ifl ();

    draw_arbiter #(.NUM_REQ(4), .HIPRI_EN(1), .TIMEOUT(TO), .CW(15)) dut_h (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifh)
    );

    draw_arbiter #(.NUM_REQ(4), .HIPRI_EN(0), .TIMEOUT(TO), .CW(15)) dut_l (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifl)
    );

    int   checks = 0;
    int   errors = 0;
    int   plot_cnt = 0;
    int   terr_cnt = 0;
    pix_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Randomise all drawer pixel inputs; queue the owner's pixel if plotted
    task automatic drive_pix(input int owner);
        pix_t p;
        ifh.x_in      = {8'($urandom), $urandom};
        ifh.y_in      = {8'($urandom), $urandom};
        ifh.colour_in = 12'($urandom);
        ifh.plot_in   = 4'($urandom);
        if (owner >= 0 && ifh.plot_in[owner]) begin
            p.x = ifh.x_in[owner*10 +: 10];
            p.y = ifh.y_in[owner*10 +: 10];
            p.c = ifh.colour_in[owner*3 +: 3];
            sb.push_back(p);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) step();
        chk("rst_grant", 32'(ifh.grant), 32'h0);
        chk("rst_plot", 32'(ifh.vga_plot), 32'h0);
        chk("rst_busy", 32'(ifh.busy), 32'h0);
        chk("rst_terr", 32'(ifh.timeout_err), 32'h0);
        chk("rst_tid", 32'(ifh.timeout_id), 32'h0);
        chk("rst_vga_x", 32'(ifh.vga_x), 32'h0);
        sb.delete();
        resetn = 1'b1;
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Scoreboard consumer: every adapter write must match the next queued pixel
    always @(posedge clk) begin
        pix_t e;
        pix_t a;
        #2;
        if (resetn) begin
            if (ifh.timeout_err) terr_cnt++;
            if (ifh.vga_plot) begin
                plot_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_plot", 32'(ifh.vga_plot), 32'h0);
                end else begin
                    e = sb.pop_front();
                    a.x = ifh.vga_x;
                    a.y = ifh.vga_y;
                    a.c = ifh.vga_colour;
                    chk("pixel", 32'(a), 32'(e));
                end
            end
        end
    end

    // Global time bound
    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[12];
        int   own;
        int   pc0;
        int   k;
        pix_t p;

        tbl[0]  = '{4'b1110, 4'b0010};
        tbl[1]  = '{4'b1110, 4'b0100};
        tbl[2]  = '{4'b1110, 4'b1000};
        tbl[3]  = '{4'b1110, 4'b0010};
        tbl[4]  = '{4'b1001, 4'b0001};
        tbl[5]  = '{4'b1001, 4'b0001};
        tbl[6]  = '{4'b1000, 4'b1000};
        tbl[7]  = '{4'b0110, 4'b0010};
        tbl[8]  = '{4'b0101, 4'b0001};
        tbl[9]  = '{4'b0100, 4'b0100};
        tbl[10] = '{4'b1010, 4'b1000};
        tbl[11] = '{4'b0011, 4'b0001};

        ifh.req = '0; ifh.done = '0; ifh.x_in = '0; ifh.y_in = '0;
        ifh.colour_in = '0; ifh.plot_in = '0;
        ifl.req = '0; ifl.done = '0; ifl.x_in = '0; ifl.y_in = '0;
        ifl.colour_in = '0; ifl.plot_in = '0;

        // ---- Basic grant / pixel / done sequence
        do_reset();
        ifh.req = 4'b0010;
        step();
        chk("t1_grant", 32'(ifh.grant), 32'h2);
        chk("t1_busy", 32'(ifh.busy), 32'h1);
        ifh.x_in[19:10] = 10'd37;
        ifh.y_in[19:10] = 10'd12;
        ifh.colour_in[5:3] = 3'b101;
        ifh.plot_in = 4'b0010;
        p.x = 10'd37; p.y = 10'd12; p.c = 3'd5;
        sb.push_back(p);
        step();
        chk("t1_vga_x", 32'(ifh.vga_x), 32'd37);
        chk("t1_vga_y", 32'(ifh.vga_y), 32'd12);
        chk("t1_vga_colour", 32'(ifh.vga_colour), 32'd5);
        chk("t1_vga_plot", 32'(ifh.vga_plot), 32'h1);
        ifh.plot_in = 4'b0000;
        step();
        ifh.done = 4'b0010;
        ifh.req  = 4'b0000;
        step();
        chk("t1_gap_grant", 32'(ifh.grant), 32'h0);
        chk("t1_gap_busy", 32'(ifh.busy), 32'h0);
        ifh.done = 4'b0000;
        step();
        chk("t1_idle_grant", 32'(ifh.grant), 32'h0);

        // ---- Table-driven arbitration order with random pixel traffic
        do_reset();
        for (int i = 0; i < 12; i++) begin
            ifh.req = tbl[i].req;
            drive_pix(-1);
            step();
            chk($sformatf("tbl%0d_grant", i), 32'(ifh.grant), 32'(tbl[i].exp));
            chk($sformatf("tbl%0d_busy", i), 32'(ifh.busy), 32'h1);
            own = oh2idx(tbl[i].exp);
            for (int c = 0; c < 3; c++) begin
                drive_pix(own);
                if (c == 0) ifh.done = ~tbl[i].exp;
                else if (c == 1) ifh.done = 4'b0000;
                else ifh.done = tbl[i].exp;
                step();
                if (c < 2) chk($sformatf("tbl%0d_hold", i), 32'(ifh.grant), 32'(tbl[i].exp));
            end
            chk($sformatf("tbl%0d_gap", i), 32'(ifh.grant), 32'h0);
            chk($sformatf("tbl%0d_gap_busy", i), 32'(ifh.busy), 32'h0);
            ifh.done = 4'b0000;
            drive_pix(-1);
            step();
            chk($sformatf("tbl%0d_idle", i), 32'(ifh.grant), 32'h0);
        end
        ifh.req = '0;
        ifh.plot_in = '0;
        step();
        chk("tbl_sb_empty", 32'(sb.size()), 32'h0);

        // ---- Priority vs pure round-robin with pointer at 2
        do_reset();
        ifh.req = 4'b0100; ifl.req = 4'b0100;
        step();
        chk("p_h_grant2", 32'(ifh.grant), 32'h4);
        chk("p_l_grant2", 32'(ifl.grant), 32'h4);
        ifh.done = 4'b0100; ifl.done = 4'b0100;
        step();
        ifh.done = 4'b0000; ifl.done = 4'b0000;
        ifh.req = 4'b1001; ifl.req = 4'b1001;
        step();
        step();
        chk("p_h_hipri", 32'(ifh.grant), 32'h1);
        chk("p_l_rr3", 32'(ifl.grant), 32'h8);
        ifh.done = 4'b0001; ifl.done = 4'b1000;
        step();
        ifh.done = 4'b0000; ifl.done = 4'b0000;
        step();
        step();
        chk("p_h_again0", 32'(ifh.grant), 32'h1);
        chk("p_l_then0", 32'(ifl.grant), 32'h1);
        ifh.req = '0; ifl.req = '0;
        step();
        step();

        // ---- Full-screen blit: 19200 pixels, no watchdog trip
        do_reset();
        pc0 = plot_cnt;
        ifh.req = 4'b0001;
        step();
        chk("blit_grant", 32'(ifh.grant), 32'h1);
        for (int i = 0; i < 19200; i++) begin
            ifh.plot_in = 4'b0001;
            ifh.x_in[9:0] = 10'(i % 160);
            ifh.y_in[9:0] = 10'(i / 160);
            ifh.colour_in[2:0] = 3'(i % 8);
            p.x = 10'(i % 160); p.y = 10'(i / 160); p.c = 3'(i % 8);
            sb.push_back(p);
            if (i == 19199) ifh.done = 4'b0001;
            step();
        end
        ifh.done = '0; ifh.plot_in = '0; ifh.req = '0;
        chk("blit_release", 32'(ifh.grant), 32'h0);
        step();
        chk("blit_plot_count", 32'(plot_cnt - pc0), 32'd19200);
        chk("blit_no_timeout", 32'(terr_cnt), 32'h0);

        // ---- Watchdog revokes requester 2
        ifh.req = 4'b0100;
        step();
        chk("wd_grant", 32'(ifh.grant), 32'h4);
        k = 0;
        while (k < TO + 100) begin
            step();
            k++;
            if (ifh.timeout_err) break;
        end
        chk("wd_latency", 32'(k), 32'(TO));
        chk("wd_id", 32'(ifh.timeout_id), 32'd2);
        chk("wd_grant_drop", 32'(ifh.grant), 32'h0);
        ifh.req = '0;
        step();
        chk("wd_pulse_single", 32'(ifh.timeout_err), 32'h0);
        chk("wd_id_hold", 32'(ifh.timeout_id), 32'd2);
        chk("wd_err_count", 32'(terr_cnt), 32'd1);
        step();

        // ---- Requester 3: foreign plot ignored, withdraw releases
        ifh.req = 4'b1000;
        step();
        chk("w_grant3", 32'(ifh.grant), 32'h8);
        ifh.x_in = {8'($urandom), $urandom};
        ifh.plot_in = 4'b0010;
        step();
        chk("w_foreign_plot", 32'(ifh.vga_plot), 32'h0);
        ifh.x_in = {8'($urandom), $urandom};
        ifh.y_in = {8'($urandom), $urandom};
        ifh.colour_in = 12'($urandom);
        ifh.plot_in = 4'b1010;
        p.x = ifh.x_in[39:30]; p.y = ifh.y_in[39:30]; p.c = ifh.colour_in[11:9];
        sb.push_back(p);
        step();
        chk("w_own_plot", 32'(ifh.vga_plot), 32'h1);
        ifh.req = '0;
        ifh.plot_in = '0;
        step();
        chk("w_release", 32'(ifh.grant), 32'h0);
        chk("w_release_busy", 32'(ifh.busy), 32'h0);
        step();

        // ---- Asynchronous reset mid-grant
        ifh.req = 4'b0010;
        step();
        chk("ar_grant", 32'(ifh.grant), 32'h2);
        ifh.x_in = {8'($urandom), $urandom};
        ifh.plot_in = 4'b0010;
        p.x = ifh.x_in[19:10]; p.y = ifh.y_in[19:10]; p.c = ifh.colour_in[5:3];
        sb.push_back(p);
        step();
        chk("ar_plot_before", 32'(ifh.vga_plot), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_grant_clr", 32'(ifh.grant), 32'h0);
        chk("ar_plot_clr", 32'(ifh.vga_plot), 32'h0);
        chk("ar_busy_clr", 32'(ifh.busy), 32'h0);
        sb.delete();
        ifh.plot_in = '0;
        ifh.req = 4'b0011;
        step();
        step();
        resetn = 1'b1;
        step();
        chk("ar_first_req0", 32'(ifh.grant), 32'h1);
        ifh.req = '0;
        step();
        step();
        chk("final_sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
